// File: rtl/mc_pkg.sv
// ----------------------------------------------------------------------------
// mc_pkg
// Shared constants and types for the Monte Carlo multipath core.
//   - Table entry format: unsigned 3.15 (DATA_W bits, FRAC_IN fraction bits).
//   - Product format: unsigned 4.14. The 6.30 full product is truncated by
//     dropping its top PROD_DROP_MSB bits and its bottom PROD_LSB bits.
//   - Accumulator: ACC_W bits with FRAC_OUT fraction bits. This is wide enough
//     for T_STEPS maximum products without overflow.
//   - FSM state encoding for the core controller.
// ----------------------------------------------------------------------------
package mc_pkg;

  localparam int DATA_W   = 18;
  localparam int FRAC_IN  = 15;
  localparam int FRAC_OUT = 14;
  localparam int T_STEPS  = 512;
  localparam int LOG_T    = 9;
  localparam int PATH_W   = 10;
  localparam int PCNT_W   = 8;
  localparam int ACC_W    = DATA_W + LOG_T;

  // Cycles from step accept to product valid: one table read stage plus two
  // multiplier register stages.
  localparam int MULT_LAT = 3;

  localparam int PROD_DROP_MSB = 2;
  localparam int PROD_LSB      = 2 * FRAC_IN - FRAC_OUT;
  localparam int PROD_MSB      = 2 * DATA_W - 1 - PROD_DROP_MSB;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } mc_state_e;

endpackage

// File: rtl/mc_bank_ram.sv
// ----------------------------------------------------------------------------
// mc_bank_ram
// Double-buffered lookup table with two banks. Each bank has 2**ADDR_W words.
// Reads are synchronous: oRdData is registered and comes from bank iRdBank.
// Writes go to bank iWrBank. The owner drives iWrBank with the bank opposite
// the one it reads from, so the live bank is never rewritten under a job.
// Ports:
//   CLK        in   clock, rising edge
//   iRdBank    in   read bank select
//   iRdAddr    in   read address
//   oRdData    out  registered read data
//   iWE        in   write enable
//   iWrBank    in   write bank select
//   iWrAddr    in   write address
//   iWrData    in   write data
// ----------------------------------------------------------------------------
module mc_bank_ram #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 18
) (
  input  logic              CLK,
  input  logic              iRdBank,
  input  logic [ADDR_W-1:0] iRdAddr,
  output logic [DATA_W-1:0] oRdData,
  input  logic              iWE,
  input  logic              iWrBank,
  input  logic [ADDR_W-1:0] iWrAddr,
  input  logic [DATA_W-1:0] iWrData
);

  logic [DATA_W-1:0] mem0 [2**ADDR_W];
  logic [DATA_W-1:0] mem1 [2**ADDR_W];

  always_ff @(posedge CLK) begin
    if (iWE && !iWrBank) mem0[iWrAddr] <= iWrData;
    if (iWE &&  iWrBank) mem1[iWrAddr] <= iWrData;
    oRdData <= iRdBank ? mem1[iRdAddr] : mem0[iRdAddr];
  end

endmodule

// File: rtl/mc_multipath_core.sv
// ----------------------------------------------------------------------------
// mc_multipath_core
// Monte Carlo path summation core. It accepts one Brownian table index per
// time step for each path in a job. Each path has T_STEPS steps. For each step
// the core forms sigma[idx] * mu[t] from two double-buffered tables and sums
// the products of a path into one result. The result register holds one
// entry and uses a valid/ready handshake.
// Optional feature macro: MC_PATH_MAX_EN. When defined, the core adds the
// output oMax. oMax carries the largest product in the path and uses the same
// handshake as oAcc.
// Ports:
//   CLK                     in   clock, rising edge
//   iRstN                   in   asynchronous active-low reset
//   iStart/iNumPaths/iSwitch in  job start, path count and read bank; sampled in IDLE
//   iSigmaWE/...Address/...Data in sigma table write (targets bank ~iSwitch)
//   iMuWE/...Address/...Data    in mu table write (targets bank ~iSwitch)
//   iWIdx/iWValid/oWReady   step index stream
//   oAcc/oAccValid/iAccReady path result handshake (oMax when enabled)
//   oBusy                   out  controller not idle
//   oDone                   out  one-cycle pulse once the job's last result is taken
// ----------------------------------------------------------------------------
module mc_multipath_core
  import mc_pkg::*;
(
  input  logic              CLK,
  input  logic              iRstN,
  input  logic              iStart,
  input  logic [PCNT_W-1:0] iNumPaths,
  input  logic              iSwitch,
  input  logic              iSigmaWE,
  input  logic [PATH_W-1:0] iSigmaWriteAddress,
  input  logic [DATA_W-1:0] iSigmaWriteData,
  input  logic              iMuWE,
  input  logic [LOG_T-1:0]  iMuWriteAddress,
  input  logic [DATA_W-1:0] iMuWriteData,
  input  logic [PATH_W-1:0] iWIdx,
  input  logic              iWValid,
  output logic              oWReady,
`ifdef MC_PATH_MAX_EN
  output logic [DATA_W-1:0] oMax,
`endif
  output logic [ACC_W-1:0]  oAcc,
  output logic              oAccValid,
  input  logic              iAccReady,
  output logic              oBusy,
  output logic              oDone
);

  function automatic logic [DATA_W-1:0] trunc_prod(input logic [2*DATA_W-1:0] full);
    return full[PROD_MSB -: DATA_W];
  endfunction

  mc_state_e         state, state_nx;
  logic [LOG_T-1:0]  t_cnt;
  logic [PCNT_W-1:0] path_cnt, num_paths;
  logic              rd_bank;
  logic              t_last, path_last, step_acc, take, job_live;
  logic              sig_we, mu_we;

  logic [DATA_W-1:0]   sig_p0, mu_p0;
  logic                vld_p0, first_p0, last_p0;
  logic [2*DATA_W-1:0] prod_p1, prod_p2;
  logic                vld_p1, first_p1, last_p1;
  logic                vld_p2, first_p2, last_p2;
  logic [DATA_W-1:0]   prod_s;
  logic [ACC_W-1:0]    acc, acc_sum;

  assign t_last    = (t_cnt == LOG_T'(T_STEPS - 1));
  assign path_last = (path_cnt == num_paths - PCNT_W'(1));
  assign step_acc  = iWValid && oWReady;
  assign take      = oAccValid && iAccReady;
  assign job_live  = (state == RUN) || (state == DRAIN);

  // Block a write only if it would hit the bank that a running job reads.
  // Writes to the bank opposite the live iSwitch normally avoid this case.
  assign sig_we = iSigmaWE && !(job_live && ((~iSwitch) == rd_bank));
  assign mu_we  = iMuWE    && !(job_live && ((~iSwitch) == rd_bank));

  always_comb begin
    state_nx = state;
    oWReady  = 1'b0;
    oBusy    = (state != IDLE);
    oDone    = 1'b0;
    case (state)
      IDLE: if (iStart) state_nx = (iNumPaths != '0) ? RUN : FIN;
      RUN: begin
        // A path's last step would write the result register about MULT_LAT
        // cycles later. Hold it back while that register is still occupied.
        oWReady = !(t_last && oAccValid && !iAccReady);
        if (iWValid && oWReady && t_last && path_last) state_nx = DRAIN;
      end
      DRAIN: if (oAccValid && iAccReady) state_nx = FIN;
      FIN: begin
        oDone    = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Stage p0: synchronous table reads. The mu table is addressed by the step.
  mc_bank_ram #(.ADDR_W(PATH_W), .DATA_W(DATA_W)) u_sigma (
    .CLK     (CLK),
    .iRdBank (rd_bank),
    .iRdAddr (iWIdx),
    .oRdData (sig_p0),
    .iWE     (sig_we),
    .iWrBank (~iSwitch),
    .iWrAddr (iSigmaWriteAddress),
    .iWrData (iSigmaWriteData)
  );

  mc_bank_ram #(.ADDR_W(LOG_T), .DATA_W(DATA_W)) u_mu (
    .CLK     (CLK),
    .iRdBank (rd_bank),
    .iRdAddr (t_cnt),
    .oRdData (mu_p0),
    .iWE     (mu_we),
    .iWrBank (~iSwitch),
    .iWrAddr (iMuWriteAddress),
    .iWrData (iMuWriteData)
  );

  assign prod_s  = trunc_prod(prod_p2);
  assign acc_sum = first_p2 ? ACC_W'(prod_s) : acc + ACC_W'(prod_s);

`ifdef MC_PATH_MAX_EN
  logic [DATA_W-1:0] max_r, max_nx;
  assign max_nx = (first_p2 || (prod_s > max_r)) ? prod_s : max_r;
`endif

  always_ff @(posedge CLK or negedge iRstN) begin
    if (!iRstN) begin
      state     <= IDLE;
      t_cnt     <= '0;
      path_cnt  <= '0;
      num_paths <= '0;
      rd_bank   <= 1'b0;
      vld_p0    <= 1'b0;
      first_p0  <= 1'b0;
      last_p0   <= 1'b0;
      vld_p1    <= 1'b0;
      first_p1  <= 1'b0;
      last_p1   <= 1'b0;
      vld_p2    <= 1'b0;
      first_p2  <= 1'b0;
      last_p2   <= 1'b0;
      oAccValid <= 1'b0;
      oAcc      <= '0;
`ifdef MC_PATH_MAX_EN
      oMax      <= '0;
`endif
    end else begin
      state <= state_nx;
      if (state == IDLE && iStart) begin
        num_paths <= iNumPaths;
        rd_bank   <= iSwitch;
        t_cnt     <= '0;
        path_cnt  <= '0;
      end else if (step_acc) begin
        t_cnt <= t_cnt + LOG_T'(1);
        if (t_last) path_cnt <= path_cnt + PCNT_W'(1);
      end
      vld_p0   <= step_acc;
      first_p0 <= (t_cnt == '0);
      last_p0  <= t_last;
      // Stage p1: first multiplier register
      vld_p1   <= vld_p0;
      first_p1 <= first_p0;
      last_p1  <= last_p0;
      // Stage p2: second multiplier register, product valid
      vld_p2   <= vld_p1;
      first_p2 <= first_p1;
      last_p2  <= last_p1;
      // The backpressure rule ensures that a new result never lands on an
      // occupied, unread entry. A load therefore takes priority over a clear.
      if (vld_p2 && last_p2) begin
        oAcc      <= acc_sum;
        oAccValid <= 1'b1;
`ifdef MC_PATH_MAX_EN
        oMax      <= max_nx;
`endif
      end else if (take) begin
        oAccValid <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    prod_p1 <= sig_p0 * mu_p0;
    prod_p2 <= prod_p1;
    if (vld_p2) acc <= acc_sum;
`ifdef MC_PATH_MAX_EN
    if (vld_p2) max_r <= max_nx;
`endif
  end

endmodule

// File: tb/tb_mc_multipath_core.sv
// ----------------------------------------------------------------------------
// tb_mc_multipath_core
// Randomized bench for mc_multipath_core. An array model of both table banks
// gives the expected path sums (and path maxima when MC_PATH_MAX_EN is
// defined). Each sum is computed directly from the arithmetic rules of the
// core.
// ----------------------------------------------------------------------------
module tb_mc_multipath_core;
  import mc_pkg::*;

  logic              CLK = 1'b0;
  logic              iRstN;
  logic              iStart;
  logic [PCNT_W-1:0] iNumPaths;
  logic              iSwitch;
  logic              iSigmaWE;
  logic [PATH_W-1:0] iSigmaWriteAddress;
  logic [DATA_W-1:0] iSigmaWriteData;
  logic              iMuWE;
  logic [LOG_T-1:0]  iMuWriteAddress;
  logic [DATA_W-1:0] iMuWriteData;
  logic [PATH_W-1:0] iWIdx;
  logic              iWValid;
  logic              oWReady;
  logic [ACC_W-1:0]  oAcc;
  logic              oAccValid;
  logic              iAccReady;
  logic              oBusy;
  logic              oDone;
`ifdef MC_PATH_MAX_EN
  logic [DATA_W-1:0] oMax;
`endif

  mc_multipath_core dut (
    .CLK                (CLK),
    .iRstN              (iRstN),
    .iStart             (iStart),
    .iNumPaths          (iNumPaths),
    .iSwitch            (iSwitch),
    .iSigmaWE           (iSigmaWE),
    .iSigmaWriteAddress (iSigmaWriteAddress),
    .iSigmaWriteData    (iSigmaWriteData),
    .iMuWE              (iMuWE),
    .iMuWriteAddress    (iMuWriteAddress),
    .iMuWriteData       (iMuWriteData),
    .iWIdx              (iWIdx),
    .iWValid            (iWValid),
    .oWReady            (oWReady),
`ifdef MC_PATH_MAX_EN
    .oMax               (oMax),
`endif
    .oAcc               (oAcc),
    .oAccValid          (oAccValid),
    .iAccReady          (iAccReady),
    .oBusy              (oBusy),
    .oDone              (oDone)
  );

  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_pass = 0;

  // Table model and job stimulus
  longint unsigned sig_m [2][1024];
  longint unsigned mu_m  [2][512];
  int              idx_a [4*512];
  longint unsigned exp_sum [4];
  longint unsigned exp_max [4];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Product rule: 3.15 x 3.15 -> keep bits 33:16 (4.14), truncated.
  function automatic longint unsigned mprod(input longint unsigned a, input longint unsigned b);
    return ((a * b) >> 16) & 64'h3FFFF;
  endfunction

  // mode 0: all 1.0, mode 1: sigma 2.0 / mu 1.0, mode 2: ramps
  task automatic fill(input bit bank, input int mode);
    @(negedge CLK);
    iSwitch = ~bank;
    for (int a = 0; a < 1024; a++) begin
      longint unsigned s, m;
      s = (mode == 0) ? 64'h8000 : (mode == 1) ? 64'h10000 : longint'(a) << 8;
      m = (mode == 2) ? 64'h8000 + longint'(a % 512) * 16 : 64'h8000;
      iSigmaWE = 1'b1; iSigmaWriteAddress = PATH_W'(a); iSigmaWriteData = DATA_W'(s);
      iMuWE = (a < 512); iMuWriteAddress = LOG_T'(a); iMuWriteData = DATA_W'(m);
      sig_m[bank][a] = s;
      if (a < 512) mu_m[bank][a] = m;
      @(negedge CLK);
    end
    iSigmaWE = 1'b0; iMuWE = 1'b0;
  endtask

  task automatic start_job(input int np, input bit bank);
    for (int i = 0; i < np * T_STEPS; i++) idx_a[i] = $urandom_range(1023);
    for (int p = 0; p < np; p++) begin
      exp_sum[p] = 0; exp_max[p] = 0;
      for (int t = 0; t < T_STEPS; t++) begin
        longint unsigned pr;
        pr = mprod(sig_m[bank][idx_a[p*T_STEPS+t]], mu_m[bank][t]);
        exp_sum[p] += pr;
        if (pr > exp_max[p]) exp_max[p] = pr;
      end
    end
    @(negedge CLK);
    iStart = 1'b1; iNumPaths = PCNT_W'(np); iSwitch = bank;
    @(negedge CLK);
    iStart = 1'b0; iNumPaths = PCNT_W'($urandom_range(255));
  endtask

  task automatic run_job(input string nm, input int np, input bit bank, input int vpct,
                         input int rdy_hold, input int rdy_pct, input bit wr_other,
                         input bit tog_sw, input int exp_stall);
    int total, step_i, cyc, got, first_stall, last_take, done_cyc, budget;
    start_job(np, bank);
    total = np * T_STEPS; budget = total * 4 + 3000;
    step_i = 0; cyc = 0; got = 0; first_stall = -1; last_take = -1; done_cyc = -1;
    while (done_cyc < 0 && cyc < budget) begin
      iWValid   = (step_i < total) && ($urandom_range(99) < vpct);
      iWIdx     = (step_i < total) ? PATH_W'(idx_a[step_i]) : '0;
      iAccReady = (cyc >= rdy_hold) && ($urandom_range(99) < rdy_pct);
      if (tog_sw) iSwitch = 1'($urandom_range(1));
      if (wr_other) begin
        iSigmaWE = 1'b1; iSigmaWriteAddress = PATH_W'(cyc % 1024); iSigmaWriteData = 18'h10000;
        iMuWE = 1'b1; iMuWriteAddress = LOG_T'(cyc % 512); iMuWriteData = 18'h08000;
        sig_m[~bank][cyc % 1024] = 64'h10000;
        mu_m[~bank][cyc % 512] = 64'h8000;
      end
      #1;
      if (oDone) done_cyc = cyc;
      if (iWValid && !oWReady && first_stall < 0) first_stall = step_i;
      if (oAccValid && iAccReady) begin
        if (got < np) begin
          chk({nm, "_acc"}, 64'(oAcc), exp_sum[got]);
`ifdef MC_PATH_MAX_EN
          chk({nm, "_max"}, 64'(oMax), exp_max[got]);
`endif
        end else chk({nm, "_extra_result"}, got, np);
        got++; last_take = cyc;
      end
      if (iWValid && oWReady) step_i++;
      @(negedge CLK);
      cyc++;
    end
    iWValid = 1'b0; iAccReady = 1'b0; iSigmaWE = 1'b0; iMuWE = 1'b0;
    chk({nm, "_done_seen"}, done_cyc >= 0, 1);
    chk({nm, "_results"}, got, np);
    chk({nm, "_steps"}, step_i, total);
    chk({nm, "_done_lat"}, done_cyc, last_take + 1);
    if (exp_stall >= 0) chk({nm, "_first_stall_step"}, first_stall, exp_stall);
  endtask

  initial begin
    int k, guard;
    iRstN = 1'b0; iStart = 1'b0; iNumPaths = '0; iSwitch = 1'b0;
    iSigmaWE = 1'b0; iSigmaWriteAddress = '0; iSigmaWriteData = '0;
    iMuWE = 1'b0; iMuWriteAddress = '0; iMuWriteData = '0;
    iWIdx = '0; iWValid = 1'b0; iAccReady = 1'b0;
    repeat (3) @(negedge CLK);
    #1;
    chk("rst_wready", oWReady, 0);
    chk("rst_accvalid", oAccValid, 0);
    chk("rst_acc", 64'(oAcc), 0);
    chk("rst_busy", oBusy, 0);
    chk("rst_done", oDone, 0);
    @(negedge CLK); iRstN = 1'b1;

    // 1: unit tables, single path
    fill(0, 0);
    fill(1, 0);
    run_job("t1", 1, 0, 100, 0, 100, 0, 0, -1);

    // 2: results held back, stall on path 1's last step
    run_job("t2", 3, 0, 100, 1500, 100, 0, 0, 2 * T_STEPS - 1);

    // 3: rewrite bank 1 during a bank-0 job, then read bank 1
    run_job("t3a", 2, 0, 100, 0, 100, 1, 0, -1);
    run_job("t3b", 2, 1, 100, 0, 100, 0, 0, -1);

    // 4: zero-path job
    @(negedge CLK); iStart = 1'b1; iNumPaths = '0;
    @(negedge CLK); iStart = 1'b0; #1;
    chk("t4_busy", oBusy, 1);
    chk("t4_done", oDone, 1);
    chk("t4_accvalid", oAccValid, 0);
    @(negedge CLK); #1;
    chk("t4_busy_after", oBusy, 0);
    chk("t4_done_after", oDone, 0);
    chk("t4_accvalid_after", oAccValid, 0);

    // 5: reset at step 100 of a running job
    start_job(2, 0);
    k = 0; guard = 0;
    while (k < 100 && guard < 1000) begin
      iWValid = 1'b1; iWIdx = PATH_W'(idx_a[k]); iAccReady = 1'b1;
      #1;
      if (oWReady) k++;
      @(negedge CLK); guard++;
    end
    chk("t5_reached_step", k, 100);
    #1; iRstN = 1'b0;
    @(posedge CLK); #1;
    chk("t5_wready", oWReady, 0);
    chk("t5_busy", oBusy, 0);
    chk("t5_accvalid", oAccValid, 0);
    chk("t5_acc", 64'(oAcc), 0);
    chk("t5_done", oDone, 0);
    @(negedge CLK); iRstN = 1'b1; iWValid = 1'b0; iAccReady = 1'b0;
    fill(0, 0);
    run_job("t5_new", 1, 0, 100, 0, 100, 0, 0, -1);

    // 6: ramp tables, random valid/ready, iSwitch wiggling mid-job
    fill(0, 2);
    run_job("t6", 2, 0, 50, 0, 70, 0, 1, -1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
